// File: rtl/data_mem_responder_if.sv
// Bus between the core's data-memory port and data_mem_responder.
//   req_i/we_i/addr_i/data_i : request (core -> responder)
//   busy_o                   : high while a request is held
//   ack_o                    : one-cycle completion pulse
//   data_o/err_o             : load data and fault flag, valid in the ack cycle
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        ack_o;
  logic [31:0] data_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  busy_o, ack_o, data_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output busy_o, ack_o, data_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface.
// Accepts one load/store per handshake in IDLE, waits LATENCY cycles, then
// commits the access on the WAIT->RESP edge and pulses ack_o for one cycle.
// Storage is DEPTH x 32-bit words addressed by byte address.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : request/response signals (slave side of data_mem_responder_if)
module data_mem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  data_mem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic [29:0] idx;
  logic        fault;
  logic        commit;

  assign idx    = addr_q[31:2];
  // Full-width index compare so out-of-range addresses never alias into the array.
  assign fault  = (addr_q[1:0] != 2'b00) || (idx >= 30'(DEPTH));
  assign commit = (state == S_WAIT) && (cnt == '0);

  assign bus.busy_o = (state != S_IDLE);
  // Decoded from the state register so it drops asynchronously with reset.
  assign bus.ack_o  = (state == S_RESP);
  assign bus.data_o = rdata_q;
  assign bus.err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.data_i;
            cnt     <= 4'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_RESP;
            if (fault) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              err_q   <= 1'b0;
              rdata_q <= we_q ? '0 : mem[idx[IW-1:0]];
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Array has no reset; the rst_i term blocks a commit on an edge that
  // coincides with reset assertion.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && we_q && !fault) begin
      mem[idx[IW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAT   = 3;
  localparam int unsigned LAT1  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus)
  );
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus1)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_d = '0;
  logic        last_e = 1'b0;

  function automatic logic is_fault(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  // One full transaction on dut with inputs scrambled while it is busy.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d, input string name);
    logic [31:0] ed;
    logic        ee;
    int unsigned lat;
    logic        seen;
    ee = is_fault(a);
    ed = (ee || we) ? 32'h0 : model[a[6:2]];
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.data_i = d;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++; $display("FAIL %s accept: busy_o=%b expected 1", name, bus.busy_o);
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      bus.req_i = 1'($urandom); bus.we_i = 1'($urandom);
      bus.addr_i = $urandom; bus.data_i = $urandom;
      @(posedge clk); #1;
      lat++;
      if (bus.ack_o === 1'b1) seen = 1'b1;
      else begin
        n_tests++;
        if (bus.data_o !== last_d || bus.err_o !== last_e) begin
          n_fail++; $display("FAIL %s hold: data_o=%h err_o=%b expected %h %b", name, bus.data_o, bus.err_o, last_d, last_e);
        end
      end
    end
    n_tests++;
    if (!seen || lat != LAT) begin
      n_fail++; $display("FAIL %s latency: got %0d (seen=%b) expected %0d", name, lat, seen, LAT);
    end
    n_tests++;
    if (bus.data_o !== ed || bus.err_o !== ee) begin
      n_fail++; $display("FAIL %s result: data_o=%h err_o=%b expected %h %b", name, bus.data_o, bus.err_o, ed, ee);
    end
    if (we && !ee) model[a[6:2]] = d;
    last_d = ed; last_e = ee;
    @(negedge clk);
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL %s release: ack_o=%b busy_o=%b expected 0 0", name, bus.ack_o, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0; bus.data_i = '0;
    bus1.req_i = 0; bus1.we_i = 0; bus1.addr_i = '0; bus1.data_i = '0;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.ack_o !== 1'b0 || bus.data_o !== 32'h0 || bus.err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset: busy=%b ack=%b data=%h err=%b expected 0 0 0 0", bus.busy_o, bus.ack_o, bus.data_o, bus.err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_d = '0; last_e = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, "fill");
  endtask

  task automatic test_store_load();
    xact(1'b1, 32'h8, 32'hDEADBEEF, "st8");
    xact(1'b0, 32'h8, 32'h0, "ld8");
    n_tests++;
    if (bus.data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ld8 value: data_o=%h expected deadbeef", bus.data_o);
    end
  endtask

  task automatic test_faults();
    xact(1'b0, 32'h6, 32'h0, "ld_misaligned");
    xact(1'b0, 32'h80, 32'h0, "ld_oor");
    xact(1'b1, 32'h80, 32'h11111111, "st_oor");
    xact(1'b1, 32'h81, 32'h22222222, "st_misaligned");
    xact(1'b1, 32'h6, 32'h33333333, "st_misaligned6");
    xact(1'b0, 32'h0, 32'h0, "ld0_after_fault");
    xact(1'b0, 32'h4, 32'h0, "ld4_after_fault");
  endtask

  task automatic test_last_word();
    xact(1'b1, 32'h7C, 32'hA5A5A5A5, "st_last");
    xact(1'b0, 32'h7C, 32'h0, "ld_last");
    n_tests++;
    if (bus.data_o !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL ld_last value: data_o=%h expected a5a5a5a5", bus.data_o);
    end
    xact(1'b1, 32'hFFFFFFFC, 32'h5A5A5A5A, "st_top");
    n_tests++;
    if (bus.err_o !== 1'b1) begin
      n_fail++; $display("FAIL st_top err: err_o=%b expected 1", bus.err_o);
    end
    xact(1'b0, 32'h7C, 32'h0, "ld_last_again");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = {25'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      xact(1'($urandom), a, $urandom, "random");
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h10; bus.data_i = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.data_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_wait: ack=%b busy=%b data=%h expected 0 0 0", bus.ack_o, bus.busy_o, bus.data_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_d = '0; last_e = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.ack_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_wait no_ack: ack_o=%b expected 0 (cycle %0d)", bus.ack_o, k);
      end
    end
    xact(1'b0, 32'h10, 32'h0, "ld_after_abort");
  endtask

  task automatic test_reset_resp();
    int unsigned n;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h14; bus.data_i = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    n = 0;
    while (bus.ack_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n_tests++;
    if (bus.ack_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_resp wait: ack_o=%b expected 1", bus.ack_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.data_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_resp async: ack=%b busy=%b data=%h expected 0 0 0", bus.ack_o, bus.busy_o, bus.data_o);
    end
    model[5] = 32'h0BADF00D;
    @(negedge clk);
    rst_n = 1'b1;
    last_d = '0; last_e = 1'b0;
    xact(1'b0, 32'h14, 32'h0, "ld_after_resp_reset");
  endtask

  task automatic test_back_to_back();
    int unsigned ph;
    int unsigned acks;
    acks = 0;
    @(negedge clk);
    bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.addr_i = 32'h0; bus1.data_i = 32'h0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      ph = k % (LAT1 + 2);
      if (bus1.ack_o === 1'b1) acks++;
      n_tests++;
      if (bus1.ack_o !== (ph == LAT1) || bus1.busy_o !== (ph != LAT1 + 1)) begin
        n_fail++; $display("FAIL held_req cycle %0d: ack=%b busy=%b expected %b %b", k, bus1.ack_o, bus1.busy_o, ph == LAT1, ph != LAT1 + 1);
      end
    end
    n_tests++;
    if (acks != 7) begin
      n_fail++; $display("FAIL held_req count: acks=%0d expected 7", acks);
    end
    @(negedge clk);
    bus1.req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_faults();
    test_last_word();
    test_random();
    test_reset_wait();
    test_reset_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
